// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler that lets NUM_REQ byte sources share one UART
// transmitter. A requester holds req[i] with its byte on req_data until it
// sees ack[i]. The arbiter latches the byte, pulses tx_flag into the
// transmitter, waits for tx_done (bounded by a watchdog), then holds an idle
// guard gap before it grants again. req_lock[i], sampled at grant, lets the
// same requester keep ownership for the next byte of a packet.
//
// Handshake: req[i] is a level request qualified by req_data[8i+7:8i]. The
// byte is consumed on the edge that raises ack[i] (one-cycle, one-hot pulse).
// The requester presents the next byte or drops req[i] on the cycle after
// ack[i]; the arbiter never samples req again sooner than two cycles after ack.
// tx_flag is a one-cycle start strobe; tx_data stays stable until the next
// grant. tx_done is a one-cycle strobe, honoured only while waiting for it.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   req, req_data       per-requester request level and byte
//   req_lock            per-requester "keep ownership" flag, sampled at grant
//   ack                 one-hot byte-accepted pulse
//   tx_data, tx_flag    byte and start pulse to the transmitter
//   tx_done             end-of-frame pulse from the transmitter
//   owner               index of the last granted requester
//   busy                high whenever the FSM is not idle
//   err_timeout         one-cycle pulse when tx_done never arrived
//   dbg_state           current FSM state (0 idle, 1 wait_done, 2 gap)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int GAP_CYC  = 5208,
  parameter int WDOG_CYC = 57288
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           tx_data,
  output logic                 tx_flag,
  input  logic                 tx_done,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYC - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  // Pointer resets to the last index so requester 0 is scanned first.
  localparam logic [2:0]  PTR_RST   = 3'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic                 lock_q, lock_d;

  logic [NUM_REQ-1:0]   ack_d;
  logic [7:0]           tx_data_d;
  logic                 tx_flag_d;
  logic [2:0]           owner_d;
  logic                 err_d;

  // Arbitration signals
  logic [7:0]           req_ext;
  logic                 lock_hit;
  logic                 rr_found;
  logic [2:0]           rr_idx;
  logic [2:0]           cand;
  logic                 grant;
  logic [2:0]           grant_idx;
  logic [7:0]           grant_data;
  logic                 grant_lock;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic                 wdog_expire;
  logic                 gap_end;

  // ---------------------------------------------------------------------------
  // Arbitration: a held lock for a still-requesting owner wins outright;
  // otherwise scan pointer+1, pointer+2, ... modulo NUM_REQ. A lock whose
  // owner has dropped req simply falls through to the round-robin scan.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ext  = 8'(req);
    lock_hit = lock_q && req_ext[owner];
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 3'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!rr_found && req_ext[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
    grant     = (state_q == S_IDLE) && (lock_hit || rr_found);
    grant_idx = lock_hit ? owner : rr_idx;
  end

  // Select the granted requester's byte, lock bit and ack position.
  always_comb begin
    grant_data   = '0;
    grant_lock   = 1'b0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 3'(i)) begin
        grant_data      = req_data[8*i +: 8];
        grant_lock      = req_lock[i];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // tx_done takes priority over an expiry in the same cycle.
  assign wdog_expire = (state_q == S_WAIT_DONE) && !tx_done && (cnt_q == WDOG_LAST);
  assign gap_end     = (state_q == S_GAP) && (cnt_q == GAP_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. One counter serves both the watchdog and the gap;
  // it restarts at 0 on every state change.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done || wdog_expire) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    else                                         cnt_d = cnt_q + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_flag_d = grant;
    ack_d     = grant ? grant_onehot : '0;
    tx_data_d = grant ? grant_data : tx_data;
    owner_d   = grant ? grant_idx : owner;
    rr_ptr_d  = grant ? grant_idx : rr_ptr_q;
    err_d     = wdog_expire;

    // In idle without a grant the lock either was clear or its owner has
    // dropped req, so it is released either way.
    if (grant)                       lock_d = grant_lock;
    else if (state_q == S_IDLE)      lock_d = 1'b0;
    else if (wdog_expire)            lock_d = 1'b0;
    else                             lock_d = lock_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_flag     <= 1'b0;
      ack         <= '0;
      tx_data     <= '0;
      owner       <= '0;
      rr_ptr_q    <= PTR_RST;
      lock_q      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_flag     <= tx_flag_d;
      ack         <= ack_d;
      tx_data     <= tx_data_d;
      owner       <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      err_timeout <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, GAP_CYC=4, WDOG_CYC=64).
// A requester model feeds bytes from per-requester source queues, a
// transmitter model answers tx_flag with tx_done after done_delay cycles, and
// a monitor checks each tx_flag / err_timeout against hand-computed entries
// pushed by the test sequence.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int GAP = 4;
  localparam int WD  = 64;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic [NR-1:0]   req      = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_lock = '0;
  logic [NR-1:0]   ack;
  logic [7:0]      tx_data;
  logic            tx_flag;
  logic            tx_done;
  logic [2:0]      owner;
  logic            busy;
  logic            err_timeout;
  logic [1:0]      dbg_state;

  logic tx_done_model = 1'b0;
  logic tx_done_inj   = 1'b0;
  assign tx_done = tx_done_model | tx_done_inj;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYC(GAP), .WDOG_CYC(WD)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_flag     (tx_flag),
    .tx_done     (tx_done),
    .owner       (owner),
    .busy        (busy),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [26:0] exp_q[$];     // {cycle[15:0], requester[2:0], byte[7:0]}
  logic [15:0] err_q[$];     // expected err_timeout cycles
  logic [8:0]  src_q[NR][$]; // per-requester {lock, byte}
  logic [26:0] mon_e;
  logic [8:0]  src_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic offer(input int i, input logic [7:0] d, input logic l);
    src_q[i].push_back({l, d});
  endtask

  task automatic expect_grant(input int i, input logic [7:0] d, input int c);
    exp_q.push_back({16'(c), 3'(i), d});
  endtask

  // Land at posedge c + 1 time unit.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Land on the negedge inside cycle c.
  task automatic at_neg(input int c);
    goto(c);
    @(negedge sys_clk);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (!busy && req == '0 && exp_q.size() == 0 && err_q.size() == 0) break;
      @(posedge sys_clk);
      #1;
    end
    chk("wait_idle_bound", 32'(k >= 3000), 32'd0);
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Requester model: raise req with the queue head; on ack present the next
  // byte or drop req.
  // ---------------------------------------------------------------------------
  initial forever begin
    @(posedge sys_clk);
    #2;
    for (int i = 0; i < NR; i++) begin
      if (req[i] && ack[i]) begin
        if (src_q[i].size() > 0) begin
          src_e = src_q[i].pop_front();
          req_data[8*i +: 8] = src_e[7:0];
          req_lock[i]        = src_e[8];
        end else begin
          req[i]      = 1'b0;
          req_lock[i] = 1'b0;
        end
      end else if (!req[i] && src_q[i].size() > 0) begin
        src_e = src_q[i].pop_front();
        req_data[8*i +: 8] = src_e[7:0];
        req_lock[i]        = src_e[8];
        req[i]             = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter model: tx_done done_delay cycles after tx_flag.
  // ---------------------------------------------------------------------------
  int done_delay    = 20;
  bit suppress_done = 1'b0;
  bit tx_active     = 1'b0;
  int tx_cnt        = 0;

  initial forever begin
    @(posedge sys_clk);
    #1;
    tx_done_model = 1'b0;
    if (!sys_rst_n) begin
      tx_active = 1'b0;
    end else begin
      if (tx_active) begin
        tx_cnt++;
        if (tx_cnt == done_delay) begin
          tx_done_model = !suppress_done;
          tx_active     = 1'b0;
        end
      end
      if (tx_flag) begin
        tx_active = 1'b1;
        tx_cnt    = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (tx_flag) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(tx_flag), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_cycle", 32'(cyc), 32'(mon_e[26:11]));
          chk("grant_owner", 32'(owner), 32'(mon_e[10:8]));
          chk("grant_data", 32'(tx_data), 32'(mon_e[7:0]));
          chk("grant_ack", 32'(ack), 32'(4'b0001 << mon_e[10:8]));
        end
      end else if (ack != '0) begin
        chk("ack_without_flag", 32'(ack), 32'd0);
      end
      if (err_timeout) begin
        if (err_q.size() == 0) chk("unexpected_err", 32'(err_timeout), 32'd0);
        else                   chk("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int t0;
  int t1;

  initial begin
    // Reset values
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_tx_flag", 32'(tx_flag), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (2) begin @(posedge sys_clk); #1; end

    // Fairness: all four request, requester 0 keeps a second byte queued.
    t0 = cyc;
    offer(0, 8'h10, 1'b0); offer(0, 8'h14, 1'b0);
    offer(1, 8'h21, 1'b0); offer(2, 8'h32, 1'b0); offer(3, 8'h43, 1'b0);
    expect_grant(0, 8'h10, t0 + 1);
    expect_grant(1, 8'h21, t0 + 27);
    expect_grant(2, 8'h32, t0 + 53);
    expect_grant(3, 8'h43, t0 + 79);
    expect_grant(0, 8'h14, t0 + 105);
    wait_idle();

    // Single request and busy fall time.
    t0 = cyc;
    offer(0, 8'h55, 1'b0);
    expect_grant(0, 8'h55, t0 + 1);
    at_neg(t0 + 1);
    chk("single_busy_rise", 32'(busy), 32'd1);
    at_neg(t0 + 25);
    chk("single_busy_last", 32'(busy), 32'd1);
    at_neg(t0 + 26);
    chk("single_busy_fall", 32'(busy), 32'd0);
    chk("single_data_hold", 32'(tx_data), 32'h55);
    wait_idle();

    // Lock for a 4-byte packet, requester 1 waiting throughout.
    t0 = cyc;
    offer(0, 8'hA0, 1'b1); offer(0, 8'hA1, 1'b1);
    offer(0, 8'hA2, 1'b1); offer(0, 8'hA3, 1'b0);
    expect_grant(0, 8'hA0, t0 + 1);
    expect_grant(0, 8'hA1, t0 + 27);
    expect_grant(0, 8'hA2, t0 + 53);
    expect_grant(0, 8'hA3, t0 + 79);
    expect_grant(1, 8'hB0, t0 + 105);
    goto(t0 + 2);
    offer(1, 8'hB0, 1'b0);
    wait_idle();

    // Lock released because the owner drops req.
    t0 = cyc;
    offer(0, 8'hC0, 1'b1);
    expect_grant(0, 8'hC0, t0 + 1);
    expect_grant(1, 8'hD0, t0 + 27);
    goto(t0 + 2);
    offer(1, 8'hD0, 1'b0);
    wait_idle();

    // Watchdog expiry, then a normal grant.
    suppress_done = 1'b1;
    t0 = cyc;
    offer(2, 8'hE2, 1'b0);
    expect_grant(2, 8'hE2, t0 + 1);
    err_q.push_back(16'(t0 + 65));
    expect_grant(3, 8'hF3, t0 + 70);
    goto(t0 + 2);
    offer(3, 8'hF3, 1'b0);
    at_neg(t0 + 65);
    chk("wdog_state_gap", 32'(dbg_state), 32'd2);
    goto(t0 + 66);
    suppress_done = 1'b0;
    at_neg(t0 + 68);
    chk("wdog_busy_gap_end", 32'(busy), 32'd1);
    at_neg(t0 + 69);
    chk("wdog_busy_idle", 32'(busy), 32'd0);
    wait_idle();

    // tx_done coincident with watchdog expiry: no error.
    done_delay = 63;
    t0 = cyc;
    offer(1, 8'h3C, 1'b0);
    expect_grant(1, 8'h3C, t0 + 1);
    at_neg(t0 + 64);
    chk("coinc_state_wait", 32'(dbg_state), 32'd1);
    at_neg(t0 + 65);
    chk("coinc_no_err", 32'(err_timeout), 32'd0);
    chk("coinc_state_gap", 32'(dbg_state), 32'd2);
    at_neg(t0 + 69);
    chk("coinc_busy_idle", 32'(busy), 32'd0);
    wait_idle();
    done_delay = 20;

    // tx_done while idle is ignored.
    t0 = cyc;
    tx_done_inj = 1'b1;
    goto(t0 + 1);
    tx_done_inj = 1'b0;
    offer(2, 8'h77, 1'b0);
    expect_grant(2, 8'h77, t0 + 2);
    at_neg(t0 + 1);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_state", 32'(dbg_state), 32'd0);
    chk("idle_done_err", 32'(err_timeout), 32'd0);
    wait_idle();

    // Reset during WAIT_DONE.
    t0 = cyc;
    offer(1, 8'h99, 1'b0);
    expect_grant(1, 8'h99, t0 + 1);
    goto(t0 + 5);
    sys_rst_n = 1'b0;
    at_neg(t0 + 5);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    chk("mid_rst_flag_ack", 32'({tx_flag, ack, err_timeout}), 32'd0);
    goto(t0 + 7);
    sys_rst_n = 1'b1;
    t1 = t0 + 8;
    goto(t1);
    offer(0, 8'h01, 1'b0);
    offer(3, 8'h02, 1'b0);
    expect_grant(0, 8'h01, t1 + 1);
    expect_grant(3, 8'h02, t1 + 27);
    wait_idle();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("err_q_drained", 32'(err_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: cycle %0d, limit 20000", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
